// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store front-end for a byte-enabled data memory with a registered read port.
// Optional LSU_RANGE_CHECK_EN: requests with non-zero address bits above the memory range complete with an error.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              in_req_valid,
  output logic              out_req_ready,
  input  logic              in_req_we,
  input  logic [ADDR_W-1:0] in_req_addr,
  input  logic [1:0]        in_req_size,
  input  logic              in_req_unsigned,
  input  logic [31:0]       in_req_wdata,
  output logic              out_rsp_valid,
  output logic [31:0]       out_rsp_rdata,
  output logic              out_rsp_err,
  output logic [MEM_AW-1:0] out_mem_addr,
  output logic              out_mem_re_web,
  output logic [31:0]       out_mem_write_data,
  output logic [3:0]        out_mem_byte_en,
  input  logic [31:0]       in_mem_data
);

  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | memory driven from the latched request for one cycle
  // WAIT  | read data on in_mem_data; extended lane captured at cycle end
  // RESP  | successful completion pulse
  // ERR   | error completion pulse, memory untouched
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

  state_t            state, state_nxt;
  logic              we_q, uns_q;
  logic [MEM_AW+1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              accept, req_bad;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext, store_data;
  logic [3:0]        store_be;
  logic              unused_addr_hi;

  assign out_req_ready = (state == IDLE) && i_rst;
  assign accept        = in_req_valid && out_req_ready;
  assign unused_addr_hi = |in_req_addr[ADDR_W-1:MEM_AW+2];

  always_comb begin
    case (in_req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = in_req_addr[0];
      2'b10:   req_bad = |in_req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
`ifdef LSU_RANGE_CHECK_EN
    if (unused_addr_hi) req_bad = 1'b1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_bad ? ERR : ISSUE;
      ISSUE:   state_nxt = we_q ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are held so the core may change its inputs after the accept edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= in_req_we;
        uns_q   <= in_req_unsigned;
        addr_q  <= in_req_addr[MEM_AW+1:0];
        size_q  <= in_req_size;
        wdata_q <= in_req_wdata;
      end
      rdata_q <= (state == WAIT) ? load_ext : 32'h0;
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = in_mem_data[7:0];
      2'd1:    byte_sel = in_mem_data[15:8];
      2'd2:    byte_sel = in_mem_data[23:16];
      default: byte_sel = in_mem_data[31:24];
    endcase
    half_sel = addr_q[1] ? in_mem_data[31:16] : in_mem_data[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = in_mem_data;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00: begin
        store_data = {4{wdata_q[7:0]}};
        store_be   = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        store_data = {2{wdata_q[15:0]}};
        store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = wdata_q;
        store_be   = 4'b1111;
      end
    endcase
  end

  // Write strobes only ever leave ISSUE; ERR never reaches ISSUE.
  always_comb begin
    out_rsp_valid      = 1'b0;
    out_rsp_err        = 1'b0;
    out_mem_re_web     = 1'b1;
    out_mem_byte_en    = 4'b0000;
    out_mem_write_data = 32'h0;
    case (state)
      ISSUE: if (we_q) begin
        out_mem_re_web     = 1'b0;
        out_mem_byte_en    = store_be;
        out_mem_write_data = store_data;
      end
      RESP: out_rsp_valid = 1'b1;
      ERR: begin
        out_rsp_valid = 1'b1;
        out_rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_mem_addr  = addr_q[MEM_AW+1:2];
  assign out_rsp_rdata = rdata_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store front-end sitting directly upstream of the byte-enabled data memory (10-bit word address, registered read port, re_web 1=read / 0=write).
- Accepts one core load/store request at a time: byte, half or word, signed or unsigned.
- Drives the memory's address, re_web, byte-lane enables and lane-replicated write data.
- Captures the registered read data, then extracts and sign/zero-extends it into a one-cycle response; misaligned or illegal requests complete with an error and no memory access.

Parameters:
- ADDR_W, 32: width of the core byte address.
- MEM_AW, 10: memory word-address width; word index = addr[MEM_AW+1:2].

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: synchronous active-low reset.
- in_req_valid, input, 1: request valid.
- out_req_ready, output, 1: block can accept a request.
- in_req_we, input, 1: 1=store, 0=load.
- in_req_addr, input, ADDR_W: byte address.
- in_req_size, input, 2: 00=byte, 01=half, 10=word, 11=illegal.
- in_req_unsigned, input, 1: zero-extend loads when 1.
- in_req_wdata, input, 32: store data, right-aligned.
- out_rsp_valid, output, 1: one-cycle completion pulse.
- out_rsp_rdata, output, 32: extended load data; 0 for stores and errors.
- out_rsp_err, output, 1: misaligned or illegal request; qualified by out_rsp_valid.
- out_mem_addr, output, MEM_AW: memory word address.
- out_mem_re_web, output, 1: memory read=1 / write=0.
- out_mem_write_data, output, 32: lane-replicated store data.
- out_mem_byte_en, output, 4: byte-lane enables.
- in_mem_data, input, 32: memory read data, valid the cycle after a read edge.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-low: sampled on the i_clk rising edge; 0 forces reset.
- Reset values, applied on any edge with i_rst=0 including mid-operation; any in-flight access is dropped:
  - state=IDLE, out_rsp_valid=0, out_rsp_rdata=0, out_rsp_err=0.
  - out_mem_re_web=1, out_mem_byte_en=0, out_mem_addr=0, out_mem_write_data=0.
  - out_req_ready=0 while i_rst=0.
- out_req_ready = (state==IDLE) && i_rst. Acceptance happens on an edge with valid && ready. The request fields are latched into internal registers; the core may change its inputs afterwards.
- Memory-side invariant: out_mem_re_web=0 only in ISSUE for an accepted, error-free store. In every other state re_web=1 and byte_en=0, so the memory never writes spuriously.
- FSM:
  - IDLE: accept -> ERR if the request is illegal or misaligned; otherwise -> ISSUE.
  - ISSUE: drive mem signals from the latched request for one cycle. Store -> RESP. Load -> WAIT.
  - WAIT: re_web=1, address held. At the end of the cycle, capture the extended lane of in_mem_data into out_rsp_rdata. -> RESP.
  - RESP: out_rsp_valid=1, err=0 for exactly one cycle. -> IDLE.
  - ERR: out_rsp_valid=1, err=1, rdata=0 for one cycle, no memory access. -> IDLE.
- Latency from the accept edge:
  - load: rsp_valid in the 3rd cycle.
  - store: rsp_valid in the 2nd cycle.
  - error: rsp_valid in the 1st cycle.
  - Throughput: next accept is possible in the cycle after RESP/ERR. The response has no backpressure.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Illegal: size=11. Both -> ERR.
- Store lanes:
  - byte: wdata[7:0] replicated into 4 lanes, byte_en = 4'b0001<<addr[1:0].
  - half: wdata[15:0] replicated into 2 lanes, byte_en = addr[1] ? 1100 : 0011.
  - word: byte_en=1111.
- Load extraction:
  - byte: lane addr[1:0] (bits 8*addr[1:0]+:8).
  - half: bits 16*addr[1]+:16.
  - Sign-extend unless in_req_unsigned, in which case zero-extend. Word is passed unchanged.
- Address bits above MEM_AW+1 are ignored (wrap), unless the optional feature below is enabled.
- in_req_valid while not ready is ignored; no queueing.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: a request whose in_req_addr[ADDR_W-1:MEM_AW+2] is non-zero is treated as an error (-> ERR, err=1, no memory access), in addition to the misaligned and illegal checks.
- Undefined: upper address bits are ignored and the access wraps into the 4 KiB memory.

Test Plan:
- Reset then word store, addr=0x10, wdata=0xDEADBEEF. Expect ISSUE cycle with mem_addr=4, re_web=0, byte_en=1111, write_data=0xDEADBEEF; rsp_valid 2 cycles after accept, err=0, rdata=0.
- Word load, addr=0x10. Expect rsp_valid 3 cycles after accept with rdata=0xDEADBEEF. Then signed byte load at 0x13 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
- Half store at 0x16, wdata=0x00008001, then signed half load at 0x16. Expect byte_en=1100, write_data=0x80018001; load rdata=0xFFFF8001.
- Half load at 0x11 and word store at 0x12. Expect error at 1 cycle after accept with err=1, rdata=0; re_web stays 1 throughout; a subsequent word load at 0x10 still returns the original data.
- Assert i_rst=0 during WAIT of a load. Expect no rsp_valid; all outputs at reset values the cycle after the edge; ready=1 the cycle after release; the next request completes normally.
- With LSU_RANGE_CHECK_EN defined, word load at 0x1010 -> err=1. Without it -> returns the word at 0x10.
